vga_trace_render: RTL

//  Pixel stage directly downstream of the VGA timing generator (1024x768, 64 MHz).

---
 rtl/vga_trace_render.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vga_trace_render.sv
// Oscilloscope trace renderer that sits behind the 1024x768 VGA timing generator.
// It draws 32 samples from a double-buffered store, swaps buffers tear-free on vsync, and registers all pixel outputs.
module vga_trace_render #(
  parameter logic [5:0] TRACE_RGB = 6'b001100,
  parameter logic [5:0] GRID_RGB  = 6'b010101,
  parameter logic [5:0] BG_RGB    = 6'b000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] x_hi,
  input  logic [4:0] x_lo,
  input  logic [4:0] y_hi,
  input  logic [5:0] y_lo,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blank,
  input  logic       grid_en,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [9:0] wr_data,
  input  logic       commit,
  output logic       commit_pend,
  output logic [5:0] rgb,
  output logic       hsync,
  output logic       vsync
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       front_q, front_d;
  logic       swap_s;
  logic       boundary_s;
  logic [9:0] bank0_q [32];
  logic [9:0] bank1_q [32];
  logic [5:0] rgb_q, rgb_d;
  logic       hs_q, vs_q;
  logic [4:0] col_s, prev_col_s;
  logic [9:0] row_s, cur_s, prev_s, lo_s, hi_s;
  logic       unused_s;

  // The top bits of the coordinates only ever select off-screen space, where blank is high.
  assign unused_s   = ^{x_hi[5], y_hi[4]};

  assign boundary_s = vsync_in & ~vs_q;
  assign col_s      = x_hi[4:0];
  assign prev_col_s = col_s - 5'd1;
  assign row_s      = {y_hi[3:0], y_lo};

  // Host writes always go to the back bank, so a write in the swap cycle ends up in the new front.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_q) begin
        bank0_q[wr_addr] <= wr_data;
      end else begin
        bank1_q[wr_addr] <= wr_data;
      end
    end
  end

  // Front-bank sample lookup for the current column and its left neighbour.
  always_comb begin
    cur_s  = front_q ? bank1_q[col_s]      : bank0_q[col_s];
    prev_s = front_q ? bank1_q[prev_col_s] : bank0_q[prev_col_s];
    if (prev_s <= cur_s) begin
      lo_s = prev_s;
      hi_s = cur_s;
    end else begin
      lo_s = cur_s;
      hi_s = prev_s;
    end
  end

  // Swap FSM: next state and swap strobe.
  always_comb begin
    state_d = state_q;
    swap_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit) begin
          if (boundary_s) begin
            swap_s = 1'b1;
          end else begin
            state_d = PEND;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (boundary_s) begin
          swap_s  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = PEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    front_d = front_q ^ swap_s;
  end

  // Pixel colour, in priority order.
  always_comb begin
    rgb_d = BG_RGB;
    if (blank) begin
      rgb_d = 6'b000000;
    end else if (row_s == cur_s) begin
      rgb_d = TRACE_RGB;
    end else if ((x_lo == 5'd0) && (col_s != 5'd0) && (row_s >= lo_s) && (row_s <= hi_s)) begin
      rgb_d = TRACE_RGB;
    end else if (grid_en && ((x_lo == 5'd0) || (y_lo == 6'd0))) begin
      rgb_d = GRID_RGB;
    end else begin
      rgb_d = BG_RGB;
    end
  end

  // Control state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      front_q <= 1'b0;
      rgb_q   <= 6'b000000;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      rgb_q   <= rgb_d;
      hs_q    <= hsync_in;
      vs_q    <= vsync_in;
    end
  end

  assign commit_pend = (state_q == PEND);
  assign rgb         = rgb_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;

endmodule
